// File: rtl/eth_rx_word_packer_if.sv
// Byte-stream input and packed-word output handshakes of eth_rx_word_packer.
// slave is the packer's view; master is the neighbouring logic's view.
interface eth_rx_word_packer_if;
    logic [31:0] s_axis_tdata;
    logic [1:0]  s_axis_byte_count;
    logic        s_axis_tvalid;
    logic        s_axis_tuser;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_udma_data_o;
    logic        m_udma_valid_o;
    logic        m_udma_ready_i;

    modport slave (
        input  s_axis_tdata, s_axis_byte_count, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
        input  m_udma_ready_i,
        output s_axis_tready, m_udma_data_o, m_udma_valid_o
    );

    modport master (
        output s_axis_tdata, s_axis_byte_count, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
        output m_udma_ready_i,
        input  s_axis_tready, m_udma_data_o, m_udma_valid_o
    );
endinterface

// File: rtl/eth_rx_word_packer.sv
// Repacks 1..4-byte RX beats into dense little-endian 32-bit uDMA words with per-frame status.
// Optional frame counters (cnt_clr_i, frames_ok_o, frames_err_o) under ETH_RX_PACK_STATS_EN.
module eth_rx_word_packer #(
    parameter int unsigned MAX_FRAME_BYTES = 1536,
    parameter int unsigned LEN_W           = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    eth_rx_word_packer_if.slave  bus,
    output logic                 frame_done_o,
    output logic [LEN_W-1:0]     frame_len_o,
    output logic                 frame_err_o
`ifdef ETH_RX_PACK_STATS_EN
    ,
    input  logic                 cnt_clr_i,
    output logic [15:0]          frames_ok_o,
    output logic [15:0]          frames_err_o
`endif
);

    typedef enum logic [1:0] {StRun, StFlush, StDrop} state_e;

    state_e             r_state, w_state_nxt;
    logic [23:0]        r_res_data, w_res_data_nxt;
    logic [1:0]         r_res_cnt, w_res_cnt_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic               r_err, w_err_nxt;
    logic [31:0]        r_out_data;
    logic               r_out_valid;
    logic               r_rdy_en;
    logic               r_done;
    logic [LEN_W-1:0]   r_flen;
    logic               r_ferr;

    logic               w_out_free;
    logic               w_tready;
    logic               w_acc;
    logic [2:0]         w_n;
    logic [2:0]         w_total;
    logic [31:0]        w_in_masked;
    logic [55:0]        w_comb;
    logic [LEN_W:0]     w_len_sum;
    logic               w_over;
    logic               w_load;
    logic [31:0]        w_load_data;
    logic               w_done;
    logic [LEN_W-1:0]   w_done_len;
    logic               w_done_err;

    assign w_out_free = !r_out_valid || bus.m_udma_ready_i;
    assign w_n        = {1'b0, bus.s_axis_byte_count} + 3'd1;
    assign w_total    = {1'b0, r_res_cnt} + w_n;
    assign w_len_sum  = {1'b0, r_len} + {{(LEN_W-2){1'b0}}, w_n};
    assign w_over     = w_len_sum > (LEN_W+1)'(MAX_FRAME_BYTES);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_in_masked[8*i +: 8] = (i < int'(w_n)) ? bus.s_axis_tdata[8*i +: 8] : 8'h00;
        end
    end

    // Residual bytes sit in the low lanes; new bytes land directly above them.
    assign w_comb = ({24'h0, w_in_masked} << {r_res_cnt, 3'b000}) | {32'h0, r_res_data};

    always_comb begin
        unique case (r_state)
            StRun:   w_tready = r_rdy_en && w_out_free;
            StDrop:  w_tready = r_rdy_en;
            default: w_tready = 1'b0;
        endcase
    end
    assign w_acc = bus.s_axis_tvalid && w_tready;

    always_comb begin
        w_state_nxt    = r_state;
        w_res_data_nxt = r_res_data;
        w_res_cnt_nxt  = r_res_cnt;
        w_len_nxt      = r_len;
        w_err_nxt      = r_err;
        w_load         = 1'b0;
        w_load_data    = 32'h0;
        w_done         = 1'b0;
        w_done_len     = r_len;
        w_done_err     = r_err;
        unique case (r_state)
            StRun: begin
                if (w_acc && w_over) begin
                    w_err_nxt = 1'b1;
                    if (!bus.s_axis_tlast) begin
                        w_state_nxt = StDrop;
                    end else if (r_res_cnt != 2'd0) begin
                        w_state_nxt = StFlush;
                    end else begin
                        w_done     = 1'b1;
                        w_done_err = 1'b1;
                        w_len_nxt  = '0;
                        w_err_nxt  = 1'b0;
                    end
                end else if (w_acc) begin
                    w_len_nxt = w_len_sum[LEN_W-1:0];
                    w_err_nxt = r_err || bus.s_axis_tuser;
                    if (w_total >= 3'd4) begin
                        w_load         = 1'b1;
                        w_load_data    = w_comb[31:0];
                        w_res_data_nxt = w_comb[55:32];
                        w_res_cnt_nxt  = w_total[1:0];
                    end else if (bus.s_axis_tlast) begin
                        w_load         = 1'b1;
                        w_load_data    = w_comb[31:0];
                        w_res_data_nxt = 24'h0;
                        w_res_cnt_nxt  = 2'd0;
                    end else begin
                        w_res_data_nxt = w_comb[23:0];
                        w_res_cnt_nxt  = w_total[1:0];
                    end
                    if (bus.s_axis_tlast) begin
                        if (w_total > 3'd4) begin
                            w_state_nxt = StFlush;
                        end else begin
                            w_done     = 1'b1;
                            w_done_len = w_len_sum[LEN_W-1:0];
                            w_done_err = w_err_nxt;
                            w_len_nxt  = '0;
                            w_err_nxt  = 1'b0;
                        end
                    end
                end
            end
            StDrop: begin
                if (w_acc && bus.s_axis_tlast) begin
                    if (r_res_cnt != 2'd0) begin
                        w_state_nxt = StFlush;
                    end else begin
                        w_state_nxt = StRun;
                        w_done      = 1'b1;
                        w_done_err  = 1'b1;
                        w_len_nxt   = '0;
                        w_err_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                if (w_out_free) begin
                    w_load         = 1'b1;
                    w_load_data    = {8'h0, r_res_data};
                    w_res_data_nxt = 24'h0;
                    w_res_cnt_nxt  = 2'd0;
                    w_state_nxt    = StRun;
                    w_done         = 1'b1;
                    w_len_nxt      = '0;
                    w_err_nxt      = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StRun;
            r_res_data  <= 24'h0;
            r_res_cnt   <= 2'd0;
            r_len       <= '0;
            r_err       <= 1'b0;
            r_out_data  <= 32'h0;
            r_out_valid <= 1'b0;
            r_rdy_en    <= 1'b0;
            r_done      <= 1'b0;
            r_flen      <= '0;
            r_ferr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_res_data <= w_res_data_nxt;
            r_res_cnt  <= w_res_cnt_nxt;
            r_len      <= w_len_nxt;
            r_err      <= w_err_nxt;
            r_rdy_en   <= 1'b1;
            r_done     <= w_done;
            if (w_load) begin
                r_out_data  <= w_load_data;
                r_out_valid <= 1'b1;
            end else if (bus.m_udma_ready_i) begin
                r_out_valid <= 1'b0;
            end
            if (w_done) begin
                r_flen <= w_done_len;
                r_ferr <= w_done_err;
            end
        end
    end

    assign bus.s_axis_tready  = w_tready;
    assign bus.m_udma_data_o  = r_out_data;
    assign bus.m_udma_valid_o = r_out_valid;
    assign frame_done_o       = r_done;
    assign frame_len_o        = r_flen;
    assign frame_err_o        = r_ferr;

`ifdef ETH_RX_PACK_STATS_EN
    logic [15:0] r_frames_ok;
    logic [15:0] r_frames_err;

    // Clear has priority over a same-cycle increment; both counters saturate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_frames_ok  <= 16'h0;
            r_frames_err <= 16'h0;
        end else if (cnt_clr_i) begin
            r_frames_ok  <= 16'h0;
            r_frames_err <= 16'h0;
        end else if (r_done) begin
            if (r_ferr && r_frames_err != 16'hFFFF) begin
                r_frames_err <= r_frames_err + 16'd1;
            end else if (!r_ferr && r_frames_ok != 16'hFFFF) begin
                r_frames_ok <= r_frames_ok + 16'd1;
            end
        end
    end

    assign frames_ok_o  = r_frames_ok;
    assign frames_err_o = r_frames_err;
`endif

endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Self-checking bench for eth_rx_word_packer: directed scenarios then random frames,
// compared against a byte-list reference model of forwarding, truncation and status.
module tb_eth_rx_word_packer;
    localparam int unsigned MAX   = 8;
    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             frame_done;
    logic [LEN_W-1:0] frame_len;
    logic             frame_err;
`ifdef ETH_RX_PACK_STATS_EN
    logic             cnt_clr = 1'b0;
    logic [15:0]      frames_ok;
    logic [15:0]      frames_err;
`endif

    eth_rx_word_packer_if bus ();

    eth_rx_word_packer #(
        .MAX_FRAME_BYTES (MAX),
        .LEN_W           (LEN_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .frame_done_o (frame_done),
        .frame_len_o  (frame_len),
        .frame_err_o  (frame_err)
`ifdef ETH_RX_PACK_STATS_EN
        ,
        .cnt_clr_i    (cnt_clr),
        .frames_ok_o  (frames_ok),
        .frames_err_o (frames_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rdy_mode = 0;  // 0: ready high, 1: random, 2: held low

    logic [31:0] exp_words[$];
    logic [16:0] exp_stat[$];  // {err, len}

    logic [31:0] fb_data[8];
    logic [1:0]  fb_bc[8];
    logic        fb_user[8];
    int          fb_n;

    logic        mon_stalled = 1'b0;
    logic [31:0] mon_held = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: forward whole beats until one would exceed MAX, then drop the rest.
    task automatic model_frame();
        logic [7:0] fwd[$];
        int         len = 0;
        logic       err = 1'b0;
        logic       dropping = 1'b0;
        logic [31:0] w;
        for (int i = 0; i < fb_n; i++) begin
            int n = int'(fb_bc[i]) + 1;
            if (!dropping && len + n > int'(MAX)) dropping = 1'b1;
            if (dropping) begin
                err = 1'b1;
            end else begin
                for (int k = 0; k < n; k++) fwd.push_back(fb_data[i][8*k +: 8]);
                len += n;
                err |= fb_user[i];
            end
        end
        for (int b = 0; b < fwd.size(); b += 4) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (b + k < fwd.size()) w[8*k +: 8] = fwd[b + k];
            end
            exp_words.push_back(w);
        end
        exp_stat.push_back({err, 16'(len)});
    endtask

    task automatic set_beat(input int i, input logic [31:0] d, input logic [1:0] bc,
                            input logic u);
        fb_data[i] = d;
        fb_bc[i]   = bc;
        fb_user[i] = u;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_beat(input int i);
        int t = 0;
        bus.s_axis_tdata      = fb_data[i];
        bus.s_axis_byte_count = fb_bc[i];
        bus.s_axis_tuser      = fb_user[i];
        bus.s_axis_tlast      = (i == fb_n - 1);
        bus.s_axis_tvalid     = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.s_axis_tready) break;
            t++;
            if (t > 200) begin
                errors++;
                checks++;
                $error("FAIL accept_timeout: observed tready=0 for %0d cycles expected 1", t);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        model_frame();
        for (int i = 0; i < fb_n; i++) begin
            send_beat(i);
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.m_udma_ready_i = 1'b1;
                1:       bus.m_udma_ready_i = ($urandom_range(0, 3) != 0);
                default: bus.m_udma_ready_i = 1'b0;
            endcase
        end
    end

    // Output monitor: word order/content, stall stability, status pulses.
    initial begin
        logic [16:0] s;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_stalled = 1'b0;
            end else begin
                if (mon_stalled) begin
                    check("stall_valid", 32'(bus.m_udma_valid_o), 32'd1);
                    check("stall_data", bus.m_udma_data_o, mon_held);
                end
                if (bus.m_udma_valid_o && bus.m_udma_ready_i) begin
                    if (exp_words.size() == 0) begin
                        errors++;
                        checks++;
                        $error("FAIL unexpected_word: observed %h expected none",
                               bus.m_udma_data_o);
                    end else begin
                        check("word", bus.m_udma_data_o, exp_words.pop_front());
                    end
                end
                mon_stalled = bus.m_udma_valid_o && !bus.m_udma_ready_i;
                mon_held    = bus.m_udma_data_o;
                if (frame_done) begin
                    if (exp_stat.size() == 0) begin
                        errors++;
                        checks++;
                        $error("FAIL unexpected_status: observed len=%0d err=%0d expected none",
                               frame_len, frame_err);
                    end else begin
                        s = exp_stat.pop_front();
                        check("frame_len", 32'(frame_len), 32'(s[15:0]));
                        check("frame_err", 32'(frame_err), 32'(s[16]));
                    end
                end
            end
        end
    end

    initial begin
        bus.s_axis_tdata      = 32'h0;
        bus.s_axis_byte_count = 2'd0;
        bus.s_axis_tvalid     = 1'b0;
        bus.s_axis_tuser      = 1'b0;
        bus.s_axis_tlast      = 1'b0;
        bus.m_udma_ready_i    = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 32'(bus.s_axis_tready), 32'd0);
        check("rst_valid", 32'(bus.m_udma_valid_o), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_tready", 32'(bus.s_axis_tready), 32'd0);
        idle(1);

        // Single-byte beats; latency of the first word.
        fb_n = 5;
        for (int i = 0; i < 5; i++) set_beat(i, 32'hC3C3C300 | 32'(8'h11 * (i + 1)), 2'd0, 1'b0);
        model_frame();
        for (int i = 0; i < 4; i++) send_beat(i);
        check("latency_valid", 32'(bus.m_udma_valid_o), 32'd1);
        check("latency_data", bus.m_udma_data_o, 32'h44332211);
        send_beat(4);
        idle(3);

        // Three-byte beats; flush holds tready low for one cycle.
        fb_n = 2;
        set_beat(0, 32'h5ACCBBAA, 2'd2, 1'b0);
        set_beat(1, 32'h5AFFEEDD, 2'd2, 1'b0);
        model_frame();
        send_beat(0);
        send_beat(1);
        @(negedge clk);
        check("flush_tready", 32'(bus.s_axis_tready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("flush_exit_tready", 32'(bus.s_axis_tready), 32'd1);
        idle(3);

        // Output stall mid-frame.
        fb_n = 2;
        set_beat(0, 32'h03020100, 2'd3, 1'b0);
        set_beat(1, 32'hA5A50504, 2'd1, 1'b0);
        model_frame();
        send_beat(0);
        rdy_mode = 2;
        repeat (5) begin
            @(negedge clk);
            check("stall_tready", 32'(bus.s_axis_tready), 32'd0);
        end
        rdy_mode = 0;
        idle(1);
        send_beat(1);
        idle(3);

        // tuser on the middle beat taints the frame only.
        fb_n = 3;
        set_beat(0, 32'h0000B2B1, 2'd1, 1'b0);
        set_beat(1, 32'h0000B4B3, 2'd1, 1'b1);
        set_beat(2, 32'h0000B6B5, 2'd1, 1'b0);
        send_frame(0);
        idle(3);

        // Oversize: 12 bytes against MAX=8.
        fb_n = 3;
        for (int i = 0; i < 3; i++) set_beat(i, 32'h01010101 * 32'(i + 1), 2'd3, 1'b0);
        send_frame(0);
        idle(3);

        // Exactly MAX bytes: no error.
        fb_n = 2;
        set_beat(0, 32'h44434241, 2'd3, 1'b0);
        set_beat(1, 32'h48474645, 2'd3, 1'b0);
        send_frame(0);
        idle(3);

        // tlast bringing total to exactly 4: one word, no flush bubble.
        fb_n = 2;
        set_beat(0, 32'h0000C2C1, 2'd1, 1'b0);
        set_beat(1, 32'h0000C4C3, 2'd1, 1'b0);
        model_frame();
        send_beat(0);
        send_beat(1);
        @(negedge clk);
        check("no_flush_tready", 32'(bus.s_axis_tready), 32'd1);
        idle(3);

        // Reset with a pending residual.
        fb_n = 4;
        set_beat(0, 32'h00000001, 2'd0, 1'b0);
        set_beat(1, 32'h00000002, 2'd0, 1'b0);
        send_beat(0);
        send_beat(1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.m_udma_valid_o), 32'd0);
        check("midrst_data", bus.m_udma_data_o, 32'h0);
        check("midrst_tready", 32'(bus.s_axis_tready), 32'd0);
        check("midrst_done", 32'(frame_done), 32'd0);
        check("midrst_len", 32'(frame_len), 32'd0);
        check("midrst_err", 32'(frame_err), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(1);
        fb_n = 1;
        set_beat(0, 32'hFFA3A2A1, 2'd2, 1'b0);
        send_frame(0);
        idle(3);

        // Random frames with random output back-pressure and input gaps.
        rdy_mode = 1;
        for (int f = 0; f < 60; f++) begin
            fb_n = $urandom_range(1, 4);
            for (int i = 0; i < fb_n; i++) begin
                set_beat(i, $urandom, 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            end
            send_frame(1);
        end
        rdy_mode = 0;
        for (int t = 0; t < 100; t++) begin
            if (exp_words.size() == 0 && exp_stat.size() == 0) break;
            idle(1);
        end
        idle(2);
        check("words_left", 32'(exp_words.size()), 32'd0);
        check("status_left", 32'(exp_stat.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
